// File: rtl/fractal_pkg.sv
// Shared fixed-point helpers and state encodings for the Mandelbrot solver pool.
// Helpers work on 64-bit signed values so that any WIDTH up to 64 and FRAC up to 30 fits.
package fractal_pkg;

    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0]   fx_wide_t;
    typedef logic signed [2*MAX_W-1:0] fx_prod_t;

    typedef enum logic [1:0] {
        CORE_IDLE,
        CORE_ITER,
        CORE_HOLD
    } core_state_t;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_RUN,
        GEN_DRAIN
    } gen_state_t;

    // FIXED_ONE for a given number of fractional bits.
    function automatic fx_wide_t fixed_one(input int frac);
        return fx_wide_t'(1) <<< frac;
    endfunction

    // ESCAPE_MAG: 4.0 expressed on the unshifted square scale (2*frac fractional bits).
    function automatic fx_wide_t escape_mag(input int frac);
        return fx_wide_t'(4) <<< (2 * frac);
    endfunction

    // Full-precision signed product, arithmetically shifted right.
    function automatic fx_prod_t mul_shift(input fx_wide_t a, input fx_wide_t b, input int shift);
        fx_prod_t p;
        p = fx_prod_t'(a) * fx_prod_t'(b);
        return p >>> shift;
    endfunction

endpackage

// File: rtl/mandel_core.sv
// One Mandelbrot iteration core: loaded with c and a pixel tag, iterates until escape
// or the iteration cap, then holds its result until the collector takes it.
module mandel_core
    import fractal_pkg::*;
#(
    parameter int WIDTH  = 27,
    parameter int FRAC   = 20,
    parameter int ITER_W = 12,
    parameter int IDX_W  = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] cr,
    input  logic signed [WIDTH-1:0] ci,
    input  logic [IDX_W-1:0]        tag_col,
    input  logic [IDX_W-1:0]        tag_row,
    input  logic [ITER_W-1:0]       max_iter,
    input  logic                    take,
    output logic                    idle,
    output logic                    hold,
    output logic [IDX_W-1:0]        col,
    output logic [IDX_W-1:0]        row,
    output logic [ITER_W-1:0]       iter
);

    localparam int MW = 2 * WIDTH + 1;
    localparam logic signed [MW-1:0] ESC = MW'(escape_mag(FRAC));

    core_state_t             state;
    logic signed [WIDTH-1:0] zr, zi, c_r, c_i;
    logic signed [WIDTH-1:0] zr_next, zi_next;
    logic signed [MW-1:0]    zr_sq, zi_sq, mag, diff;
    logic                    escape;

    always_comb begin
        zr_sq   = MW'(zr) * MW'(zr);
        zi_sq   = MW'(zi) * MW'(zi);
        mag     = zr_sq + zi_sq;
        diff    = zr_sq - zi_sq;
        escape  = mag > ESC;
        zr_next = WIDTH'(diff >>> FRAC) + c_r;
        // (2*zr*zi) >>> FRAC is exactly (zr*zi) >>> (FRAC-1).
        zi_next = WIDTH'(mul_shift(fx_wide_t'(zr), fx_wide_t'(zi), FRAC - 1)) + c_i;
    end

    // NOTE: state registers use non-blocking assignments so every core samples the
    // same pre-edge values regardless of evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CORE_IDLE;
            zr    <= '0;
            zi    <= '0;
            c_r   <= '0;
            c_i   <= '0;
            col   <= '0;
            row   <= '0;
            iter  <= '0;
        end else begin
            case (state)
                CORE_IDLE: begin
                    if (load) begin
                        state <= CORE_ITER;
                        zr    <= '0;
                        zi    <= '0;
                        iter  <= '0;
                        c_r   <= cr;
                        c_i   <= ci;
                        col   <= tag_col;
                        row   <= tag_row;
                    end
                end
                CORE_ITER: begin
                    if (escape || iter == max_iter) begin
                        state <= CORE_HOLD;
                    end else begin
                        zr   <= zr_next;
                        zi   <= zi_next;
                        iter <= iter + ITER_W'(1);
                    end
                end
                CORE_HOLD: begin
                    if (take) state <= CORE_IDLE;
                end
                default: state <= CORE_IDLE;
            endcase
        end
    end

    assign idle = (state == CORE_IDLE);
    assign hold = (state == CORE_HOLD);

endmodule

// File: rtl/multi_solver_pool.sv
// Raster generator feeding a pool of Mandelbrot cores, with a round-robin collector
// driving a single valid/ready output register.
module multi_solver_pool
    import fractal_pkg::*;
#(
    parameter int NUM_SOLVERS = 4,
    parameter int WIDTH       = 27,
    parameter int FRAC        = 20,
    parameter int ITER_W      = 12,
    parameter int IDX_W       = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] min_x,
    input  logic signed [WIDTH-1:0] min_y,
    input  logic signed [WIDTH-1:0] max_x,
    input  logic signed [WIDTH-1:0] max_y,
    input  logic signed [WIDTH-1:0] dx,
    input  logic signed [WIDTH-1:0] dy,
    input  logic [ITER_W-1:0]       max_iter,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_col,
    output logic [IDX_W-1:0]        out_row,
    output logic [ITER_W-1:0]       out_iter
);

    localparam int SEL_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam int XW    = WIDTH + 1;

    gen_state_t              state;
    logic signed [WIDTH-1:0] min_x_q, max_x_q, max_y_q, dx_q, dy_q, cx, cy;
    logic [ITER_W-1:0]       max_iter_q;
    logic [IDX_W-1:0]        cur_col, cur_row;
    logic signed [XW-1:0]    next_x, next_y;
    logic                    x_over, y_over, any_idle, issue, grant_any, out_load;
    logic [SEL_W-1:0]        issue_sel, grant_sel, last_grant, rr_idx;

    logic [NUM_SOLVERS-1:0]  core_idle, core_hold, core_load, core_take;
    logic [IDX_W-1:0]        core_col  [NUM_SOLVERS];
    logic [IDX_W-1:0]        core_row  [NUM_SOLVERS];
    logic [ITER_W-1:0]       core_iter [NUM_SOLVERS];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        next_x    = XW'(cx) + XW'(dx_q);
        next_y    = XW'(cy) + XW'(dy_q);
        x_over    = next_x > XW'(max_x_q);
        y_over    = next_y > XW'(max_y_q);
        issue_sel = '0;
        any_idle  = 1'b0;
        for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
            if (core_idle[i]) begin
                issue_sel = SEL_W'(i);
                any_idle  = 1'b1;
            end
        end
        issue     = (state == GEN_RUN) && any_idle;
        core_load = '0;
        if (issue) core_load[issue_sel] = 1'b1;

        // Descending scan: the hold core nearest after last_grant is assigned last and wins.
        grant_sel = '0;
        grant_any = 1'b0;
        rr_idx    = '0;
        for (int k = NUM_SOLVERS; k >= 1; k--) begin
            rr_idx = SEL_W'((int'(last_grant) + k) % NUM_SOLVERS);
            if (core_hold[rr_idx]) begin
                grant_sel = rr_idx;
                grant_any = 1'b1;
            end
        end
        out_load  = !out_valid || out_ready;
        core_take = '0;
        if (out_load && grant_any) core_take[grant_sel] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= GEN_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            min_x_q    <= '0;
            max_x_q    <= '0;
            max_y_q    <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            max_iter_q <= '0;
            cx         <= '0;
            cy         <= '0;
            cur_col    <= '0;
            cur_row    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                GEN_IDLE: begin
                    if (start) begin
                        min_x_q    <= min_x;
                        max_x_q    <= max_x;
                        max_y_q    <= max_y;
                        dx_q       <= dx;
                        dy_q       <= dy;
                        max_iter_q <= max_iter;
                        cx         <= min_x;
                        cy         <= min_y;
                        cur_col    <= '0;
                        cur_row    <= '0;
                        busy       <= 1'b1;
                        state      <= (max_x < min_x || max_y < min_y) ? GEN_DRAIN : GEN_RUN;
                    end
                end
                GEN_RUN: begin
                    if (issue) begin
                        if (x_over) begin
                            cx      <= min_x_q;
                            cur_col <= '0;
                            if (y_over) begin
                                state <= GEN_DRAIN;
                            end else begin
                                cy      <= next_y[WIDTH-1:0];
                                cur_row <= cur_row + IDX_W'(1);
                            end
                        end else begin
                            cx      <= next_x[WIDTH-1:0];
                            cur_col <= cur_col + IDX_W'(1);
                        end
                    end
                end
                GEN_DRAIN: begin
                    if (&core_idle && !out_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= GEN_IDLE;
                    end
                end
                default: state <= GEN_IDLE;
            endcase
        end
    end

    // Output register reloads only when empty or being consumed, so data holds under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_col    <= '0;
            out_row    <= '0;
            out_iter   <= '0;
            last_grant <= '0;
        end else if (out_load) begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_col    <= core_col[grant_sel];
                out_row    <= core_row[grant_sel];
                out_iter   <= core_iter[grant_sel];
                last_grant <= grant_sel;
            end
        end
    end

    for (genvar g = 0; g < NUM_SOLVERS; g++) begin : g_core
        mandel_core #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .ITER_W(ITER_W),
            .IDX_W (IDX_W)
        ) u_core (
            .clock   (clock),
            .reset   (reset),
            .load    (core_load[g]),
            .cr      (cx),
            .ci      (cy),
            .tag_col (cur_col),
            .tag_row (cur_row),
            .max_iter(max_iter_q),
            .take    (core_take[g]),
            .idle    (core_idle[g]),
            .hold    (core_hold[g]),
            .col     (core_col[g]),
            .row     (core_row[g]),
            .iter    (core_iter[g])
        );
    end

endmodule

// File: tb/tb_multi_solver_pool.sv
// Directed bench for multi_solver_pool: single pixels, full grids with and without
// backpressure, mid-frame reset, empty frames and ignored restarts.
module tb_multi_solver_pool;
    import fractal_pkg::*;

    localparam int N  = 4;
    localparam int W  = 27;
    localparam int F  = 20;
    localparam int IW = 12;
    localparam int XW = 11;

    logic                clock;
    logic                reset;
    logic                start;
    logic signed [W-1:0] min_x, min_y, max_x, max_y, dx, dy;
    logic [IW-1:0]       max_iter;
    logic                busy, done, out_valid, out_ready;
    logic [XW-1:0]       out_col, out_row;
    logic [IW-1:0]       out_iter;

    int errors = 0;
    int checks = 0;

    logic [XW-1:0] q_col[$];
    logic [XW-1:0] q_row[$];
    logic [IW-1:0] q_iter[$];
    int n_done, busy_bad, stab_bad, done_cyc, n_stall, timed_out;

    multi_solver_pool #(
        .NUM_SOLVERS(N),
        .WIDTH      (W),
        .FRAC       (F),
        .ITER_W     (IW),
        .IDX_W      (XW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .min_x    (min_x),
        .min_y    (min_y),
        .max_x    (max_x),
        .max_y    (max_y),
        .dx       (dx),
        .dy       (dy),
        .max_iter (max_iter),
        .busy     (busy),
        .done     (done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_col  (out_col),
        .out_row  (out_row),
        .out_iter (out_iter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic signed [W-1:0] fx(input int n);
        return W'(longint'(n) * fixed_one(F));
    endfunction

    // Hand-derived escape counts for integer c = col + i*row (valid for m >= 3).
    function automatic int exp_grid_iter(input int c, input int r, input int m);
        if (c == 0 && (r == 0 || r == 1)) return m;
        if (c == 1 && r == 0) return 3;
        if ((c == 1 && r == 1) || (c == 2 && r == 0) || (c == 0 && r == 2)) return 2;
        return 1;
    endfunction

    task automatic set_cfg(input int x0, input int x1, input int y0, input int y1,
                           input int step, input int mi);
        min_x    = fx(x0);
        max_x    = fx(x1);
        min_y    = fx(y0);
        max_y    = fx(y1);
        dx       = fx(step);
        dy       = fx(step);
        max_iter = IW'(mi);
    endtask

    // ready_mode 0: always ready; 1: low for 100 cycles, then random.
    task automatic run_frame(input int ready_mode, input int limit, input int restart_cyc);
        logic          prev_stall;
        logic [XW-1:0] pc, pr;
        logic [IW-1:0] pi;
        int            cyc, tail;
        bit            seen_done;
        q_col.delete();
        q_row.delete();
        q_iter.delete();
        n_done = 0; busy_bad = 0; stab_bad = 0; done_cyc = -1; n_stall = 0; timed_out = 0;
        prev_stall = 1'b0; pc = '0; pr = '0; pi = '0;
        seen_done = 1'b0; tail = 0;
        @(negedge clock);
        start = 1'b1;
        out_ready = (ready_mode == 0);
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (tail < 4 && cyc < limit) begin
            if (prev_stall && (out_valid !== 1'b1 || out_col !== pc || out_row !== pr || out_iter !== pi))
                stab_bad++;
            if (done === 1'b1) begin
                n_done++;
                if (!seen_done) done_cyc = cyc;
                seen_done = 1'b1;
                if (busy !== 1'b0) busy_bad++;
            end
            if (seen_done) tail++;
            if (cyc == restart_cyc) begin
                set_cfg(3, 3, 3, 3, 1, 5);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (ready_mode == 0) out_ready = 1'b1;
            else out_ready = (cyc < 100) ? 1'b0 : 1'($urandom_range(0, 1));
            if (out_valid === 1'b1 && out_ready) begin
                q_col.push_back(out_col);
                q_row.push_back(out_row);
                q_iter.push_back(out_iter);
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            if (prev_stall) n_stall++;
            pc = out_col; pr = out_row; pi = out_iter;
            @(negedge clock);
            cyc++;
        end
        if (!seen_done) timed_out = 1;
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_framing(input string name, input int exp_count);
        checks++;
        if (timed_out !== 0) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within cycle budget", name);
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d expected 1", name, n_done);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL %s_busy_in_done: busy high in %0d done cycles, expected 0", name, busy_bad);
        end
        checks++;
        if (stab_bad !== 0) begin
            errors++;
            $display("FAIL %s_stable: %0d stalled cycles changed output, expected 0", name, stab_bad);
        end
        checks++;
        if (q_col.size() !== exp_count) begin
            errors++;
            $display("FAIL %s_count: got %0d results expected %0d", name, q_col.size(), exp_count);
        end
    endtask

    task automatic verify_grid(input string name, input int ncols, input int nrows, input int maxit);
        bit seen [16][16];
        check_framing(name, ncols * nrows);
        foreach (q_col[i]) begin
            int c, r, e;
            c = int'(q_col[i]);
            r = int'(q_row[i]);
            checks++;
            if (c >= ncols || r >= nrows) begin
                errors++;
                $display("FAIL %s_tag: got (%0d,%0d) outside %0dx%0d", name, c, r, ncols, nrows);
            end else if (seen[c][r]) begin
                errors++;
                $display("FAIL %s_dup: got (%0d,%0d) twice, expected once", name, c, r);
            end else begin
                seen[c][r] = 1'b1;
                e = exp_grid_iter(c, r, maxit);
                if (int'(q_iter[i]) !== e) begin
                    errors++;
                    $display("FAIL %s_iter(%0d,%0d): got %0d expected %0d", name, c, r, q_iter[i], e);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 1, 16);
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/valid=%b expected 000", {busy, done, out_valid});
        end
        checks++;
        if (out_col !== '0 || out_row !== '0 || out_iter !== '0) begin
            errors++;
            $display("FAIL reset_data: got (%0d,%0d,%0d) expected (0,0,0)", out_col, out_row, out_iter);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single(input string name, input int x, input int y, input int mi, input int exp_iter);
        set_cfg(x, x, y, y, 1, mi);
        run_frame(0, 500, -1);
        check_framing(name, 1);
        if (q_col.size() >= 1) begin
            checks++;
            if (q_col[0] !== '0 || q_row[0] !== '0 || int'(q_iter[0]) !== exp_iter) begin
                errors++;
                $display("FAIL %s_result: got (%0d,%0d,%0d) expected (0,0,%0d)",
                         name, q_col[0], q_row[0], q_iter[0], exp_iter);
            end
        end
    endtask

    task automatic test_grid();
        set_cfg(0, 8, 0, 8, 1, 32);
        run_frame(0, 3000, -1);
        verify_grid("grid", 9, 9, 32);
    endtask

    task automatic test_backpressure();
        set_cfg(0, 8, 0, 8, 1, 32);
        run_frame(1, 6000, -1);
        verify_grid("grid_bp", 9, 9, 32);
        checks++;
        if (n_stall < 90) begin
            errors++;
            $display("FAIL grid_bp_stalls: got %0d stalled cycles expected >= 90", n_stall);
        end
    endtask

    task automatic test_reset_mid_frame();
        set_cfg(0, 8, 0, 8, 1, 32);
        out_ready = 1'b1;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (30) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy_before: got %b expected 1", busy);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_flags: got busy/done/valid=%b expected 000", {busy, done, out_valid});
        end
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_reset: got busy=%b expected 0", busy);
        end
        set_cfg(0, 1, 0, 1, 1, 16);
        run_frame(0, 500, -1);
        verify_grid("after_reset_2x2", 2, 2, 16);
    endtask

    task automatic test_empty_and_restart();
        set_cfg(1, 0, 0, 0, 1, 16);
        run_frame(0, 100, -1);
        check_framing("empty", 0);
        checks++;
        if (done_cyc < 1 || done_cyc > 3) begin
            errors++;
            $display("FAIL empty_latency: got done at cycle %0d expected 1..3", done_cyc);
        end
        set_cfg(0, 1, 0, 1, 1, 16);
        run_frame(0, 500, 3);
        verify_grid("restart_ignored", 2, 2, 16);
    endtask

    initial begin
        test_reset();
        test_single("single_origin", 0, 0, 16, 16);
        test_single("single_2_2", 2, 2, 16, 1);
        test_single("single_1_0", 1, 0, 16, 3);
        test_grid();
        test_backpressure();
        test_reset_mid_frame();
        test_empty_and_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
